// File: rtl/payload_engine_ctrl.sv
// payload_engine_ctrl: sequences engine clear, per-byte enable, pipeline drain and result reporting per packet.
module payload_engine_ctrl #(
    parameter int NUM_ENG = 16,
    parameter int LAT     = 2,
    parameter int MAX_LEN = 2048,
    parameter int ID_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_sop,
    input  logic               s_eop,
    output logic               eng_sod,
    output logic               eng_en,
    output logic [7:0]         eng_data,
    input  logic [NUM_ENG-1:0] eng_match,
    input  logic [NUM_ENG-1:0] cfg_mask,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [NUM_ENG-1:0] m_match,
    output logic [ID_W-1:0]    m_id,
    output logic [15:0]        m_len,
    output logic               m_trunc
);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, STREAM = 3'd2, DRAIN = 3'd3, REPORT = 3'd4;
    logic [2:0]         state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic               trunc_q, trunc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sod_q, sod_d;
    logic               en_q, en_d;
    logic [7:0]         data_q, data_d;
    logic               mvalid_q, mvalid_d;
    logic [NUM_ENG-1:0] mmatch_q, mmatch_d;
    logic [ID_W-1:0]    mid_q, mid_d;
    logic [15:0]        mlen_q, mlen_d;
    logic               mtrunc_q, mtrunc_d;
    logic               below_max;
    logic               accept;
    // Gated by rst_n so the port reads 0 while reset is held, even in IDLE.
    assign s_ready   = rst_n & (state_q == IDLE ? ~s_sop : state_q == STREAM);
    assign accept    = s_valid & s_ready;
    assign below_max = 32'(len_q) < 32'(MAX_LEN);
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        trunc_d  = trunc_q;
        cnt_d    = cnt_q;
        sod_d    = 1'b0;
        en_d     = 1'b0;
        data_d   = data_q;
        mvalid_d = mvalid_q;
        mmatch_d = mmatch_q;
        mid_d    = mid_q;
        mlen_d   = mlen_q;
        mtrunc_d = mtrunc_q;
        case (state_q)
            IDLE: begin
                if (s_valid && s_sop) begin
                    state_d = START;
                    sod_d   = 1'b1;
                end
            end
            START: begin
                state_d = STREAM;
                len_d   = '0;
                trunc_d = 1'b0;
            end
            STREAM: begin
                if (accept) begin
                    data_d  = s_data;
                    en_d    = below_max;
                    trunc_d = trunc_q | ~below_max;
                    len_d   = len_q == 16'hFFFF ? len_q : len_q + 16'd1;
                    if (s_eop) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(LAT - 1);
                    end
                end
            end
            DRAIN: begin
                // Loaded with LAT-1 so capture lands on the LAT-th drain cycle.
                if (cnt_q == '0) begin
                    mmatch_d = eng_match & cfg_mask;
                    mlen_d   = len_q;
                    mtrunc_d = trunc_q;
                    mvalid_d = 1'b1;
                    state_d  = REPORT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            REPORT: begin
                if (m_ready) begin
                    mvalid_d = 1'b0;
                    mid_d    = mid_q + ID_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            trunc_q  <= 1'b0;
            cnt_q    <= '0;
            sod_q    <= 1'b0;
            en_q     <= 1'b0;
            data_q   <= '0;
            mvalid_q <= 1'b0;
            mmatch_q <= '0;
            mid_q    <= '0;
            mlen_q   <= '0;
            mtrunc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            trunc_q  <= trunc_d;
            cnt_q    <= cnt_d;
            sod_q    <= sod_d;
            en_q     <= en_d;
            data_q   <= data_d;
            mvalid_q <= mvalid_d;
            mmatch_q <= mmatch_d;
            mid_q    <= mid_d;
            mlen_q   <= mlen_d;
            mtrunc_q <= mtrunc_d;
        end
    end
    assign eng_sod  = sod_q;
    assign eng_en   = en_q;
    assign eng_data = data_q;
    assign m_valid  = mvalid_q;
    assign m_match  = mmatch_q;
    assign m_id     = mid_q;
    assign m_len    = mlen_q;
    assign m_trunc  = mtrunc_q;
endmodule

// File: tb/tb_payload_engine_ctrl.sv
// tb_payload_engine_ctrl: random packets against a packet-level reference model with a toy sticky engine bank.
module tb_payload_engine_ctrl;
    localparam int NE = 16, LAT = 2, ML = 8, IW = 8, NPKT = 270;
    typedef struct packed {
        logic [15:0] m;
        logic [15:0] l;
        logic        t;
        logic [7:0]  id;
    } res_t;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic          s_valid = 1'b0, s_ready, s_sop = 1'b0, s_eop = 1'b0;
    logic [7:0]    s_data = '0;
    logic          eng_sod, eng_en;
    logic [7:0]    eng_data;
    logic [NE-1:0] eng_match = '0, cfg_mask = 16'hFFFF;
    logic          m_valid, m_ready = 1'b0, m_trunc;
    logic [NE-1:0] m_match;
    logic [IW-1:0] m_id;
    logic [15:0]   m_len;
    int n_cmp = 0, n_err = 0, cyc = 0, hold = 0;
    always #5 clk = ~clk;
    payload_engine_ctrl #(.NUM_ENG(NE), .LAT(LAT), .MAX_LEN(ML), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sop(s_sop), .s_eop(s_eop), .eng_sod(eng_sod), .eng_en(eng_en), .eng_data(eng_data),
        .eng_match(eng_match), .cfg_mask(cfg_mask), .m_valid(m_valid), .m_ready(m_ready),
        .m_match(m_match), .m_id(m_id), .m_len(m_len), .m_trunc(m_trunc)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    // Toy engine: each enabled byte sets bit data[3:0], sticky until sod.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (eng_sod) eng_match <= '0;
        else if (eng_en) eng_match <= eng_match | (16'd1 << eng_data[3:0]);
    end
    logic [7:0]  en_q[$];
    res_t        exp_q[$];
    logic [7:0]  id_ctr = '0;
    logic [15:0] acc = '0, hm = '0, hl = '0;
    logic [8:0]  hit = '0;
    logic        in_pkt = 1'b0, prev_mv = 1'b0, prev_sod = 1'b0, prev_sop_idle = 1'b0, sop_wait = 1'b0;
    int idx = 0, eop_cyc = 0, r_cyc = -10, sod_seen = 0, n_res = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pkt = 1'b0;
            en_q.delete();
            exp_q.delete();
            id_ctr = '0;
            prev_mv = 1'b0;
            prev_sod = 1'b0;
            prev_sop_idle = 1'b0;
            sod_seen = 0;
            r_cyc = -10;
        end else begin
            if (eng_en) begin
                chk("en_pending", 32'(en_q.size() > 0), 32'd1);
                if (en_q.size() > 0) chk("eng_data", 32'(eng_data), 32'(en_q.pop_front()));
            end
            if (eng_sod) begin
                chk("sod_src", 32'(prev_sop_idle), 32'd1);
                chk("sod_1cyc", 32'(prev_sod), 32'd0);
                sod_seen++;
            end
            if (cyc == r_cyc + 1) sop_wait = s_valid && s_sop;
            if (cyc == r_cyc + 2 && sop_wait) chk("sod_b2b", 32'(eng_sod), 32'd1);
            if (m_valid) begin
                chk("srdy_rpt", 32'(s_ready), 32'd0);
                if (!prev_mv) begin
                    chk("mv_pending", 32'(exp_q.size() > 0), 32'd1);
                    chk("en_left", 32'(en_q.size()), 32'd0);
                    chk("mv_lat", 32'(cyc), 32'(eop_cyc + LAT + 1));
                    if (exp_q.size() > 0) begin
                        chk("m_match", 32'(m_match), 32'(exp_q[0].m));
                        chk("m_len", 32'(m_len), 32'(exp_q[0].l));
                        chk("m_trunc", 32'(m_trunc), 32'(exp_q[0].t));
                        chk("m_id", 32'(m_id), 32'(exp_q[0].id));
                    end
                    hm = m_match;
                    hl = m_len;
                    hit = {m_id, m_trunc};
                end else begin
                    chk("hold_ml", {m_match, m_len}, {hm, hl});
                    chk("hold_it", 32'({m_id, m_trunc}), 32'(hit));
                end
                if (m_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    r_cyc = cyc;
                    id_ctr++;
                    n_res++;
                end
            end
            prev_mv = m_valid && !m_ready;
            prev_sod = eng_sod;
            prev_sop_idle = s_valid && s_sop && !s_ready && !in_pkt;
            if (s_valid && s_ready) begin
                if (!in_pkt && s_sop) begin
                    chk("sod_cnt", 32'(sod_seen), 32'd1);
                    sod_seen = 0;
                    in_pkt = 1'b1;
                    idx = 0;
                    acc = '0;
                end
                if (in_pkt) begin
                    if (idx < ML) begin
                        en_q.push_back(s_data);
                        acc |= 16'd1 << s_data[3:0];
                    end
                    idx++;
                    if (s_eop) begin
                        exp_q.push_back('{m: acc & cfg_mask, l: 16'(idx), t: idx > ML, id: id_ctr});
                        eop_cyc = cyc;
                        in_pkt = 1'b0;
                    end
                end
            end
        end
    end
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                hold--;
                m_ready = 1'b0;
            end else if ($urandom % 16 == 0) begin
                hold = 10;
                m_ready = 1'b0;
            end else m_ready = ($urandom % 3) != 0;
        end
    end
    task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
        int w = 0;
        s_valid = 1'b1;
        s_data = d;
        s_sop = sop;
        s_eop = eop;
        do begin
            @(negedge clk);
            w++;
        end while (!s_ready && w < 300);
        if (!s_ready) chk("beat_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sop = 1'b0;
        s_eop = 1'b0;
    endtask
    task automatic pkt(input int len);
        for (int i = 0; i < len; i++) begin
            beat(8'($urandom), i == 0 || ($urandom % 8 == 0), i == len - 1);
            repeat ($urandom % 4 == 0 ? $urandom_range(1, 2) : 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask
    task automatic wait_idle();
        int w = 0;
        while (exp_q.size() > 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_sr"}, 32'({s_ready, eng_sod, eng_en, m_valid, m_trunc}), 32'd0);
        chk({tag, "_data"}, 32'(eng_data), 32'd0);
        chk({tag, "_mm"}, {m_match, m_len}, 32'd0);
        chk({tag, "_id"}, 32'(m_id), 32'd0);
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        for (int k = 0; k < NPKT; k++) begin
            if (k % 16 == 0) begin
                wait_idle();
                cfg_mask = (k % 64 == 0) ? 16'hFFFF : (k % 64 == 16) ? 16'h00F0 : 16'($urandom);
            end
            repeat (k == 1 ? 3 : $urandom % 3) beat(8'($urandom), 1'b0, 1'($urandom));
            pkt(k == 0 ? 5 : k == 1 ? 4 : k == 2 ? 12 : k == 3 ? 1 : $urandom_range(1, 14));
        end
        wait_idle();
        chk("pkt_count", 32'(n_res), 32'(NPKT));
        beat(8'h11, 1'b1, 1'b0);
        beat(8'h22, 1'b0, 1'b0);
        beat(8'h33, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pkt(3);
        wait_idle();
        chk("pkt_count_post", 32'(n_res), 32'(NPKT + 1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
